// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline stall/flush sequencing for the 5-stage RV32 core.
// Covers the load-use interlock, branch/jump redirect flush and trap flush.
// It also sequences the multi-cycle MDU and keeps a saturating stall-cycle counter.
//
// MDU handshake: mdu_start is a one-cycle launch pulse, raised while the MDU
// instruction sits in E. The MDU answers with a one-cycle mdu_done pulse when
// the result is valid. E stays held until mdu_done arrives. If a trap flush or
// a timeout occurs first, the operation is cancelled with a one-cycle mdu_abort.
// A timeout also sets the sticky mdu_error flag.
module hazard_stall_ctrl #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic             use_rs1_D,
  input  logic             use_rs2_D,
  input  logic [4:0]       rd_E,
  input  logic             mem_read_E,
  input  logic             branch_E,
  input  logic             branch_flag,
  input  logic             jump_E,
  input  logic             mdu_op_E,
  input  logic             mdu_done,
  input  logic             flush_req,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_M,
  output logic             mdu_start,
  output logic             mdu_abort,
  output logic             mdu_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             dbg_state
);

  localparam int TW = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(MDU_TIMEOUT - 1);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MDU_WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;

  // Ungated control values; the output ports force these low while reset is high.
  logic s_f, s_d, s_e, f_d, f_e, f_m, m_start, m_abort;
  logic load_use, redirect;

  assign load_use = mem_read_E && (rd_E != 5'd0) &&
                    ((use_rs1_D && (rs1_D == rd_E)) || (use_rs2_D && (rs2_D == rd_E)));
  assign redirect = (branch_E && branch_flag) || jump_E;

  // Next-state and control decode, with priorities resolved per state.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    s_f     = 1'b0;
    s_d     = 1'b0;
    s_e     = 1'b0;
    f_d     = 1'b0;
    f_e     = 1'b0;
    f_m     = 1'b0;
    m_start = 1'b0;
    m_abort = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (flush_req) begin
          f_d = 1'b1;
          f_e = 1'b1;
        end else if (mdu_op_E) begin
          m_start = 1'b1;
          s_f     = 1'b1;
          s_d     = 1'b1;
          s_e     = 1'b1;
          f_m     = 1'b1;
          tmo_d   = '0;
          state_d = ST_MDU_WAIT;
        end else if (redirect) begin
          // D holds a wrong-path instruction, so a pending load-use stall is moot.
          f_d = 1'b1;
          f_e = 1'b1;
        end else if (load_use) begin
          s_f = 1'b1;
          s_d = 1'b1;
          f_e = 1'b1;
        end
      end
      ST_MDU_WAIT: begin
        if (flush_req) begin
          m_abort = 1'b1;
          f_d     = 1'b1;
          f_e     = 1'b1;
          state_d = ST_RUN;
        end else if (mdu_done) begin
          // Done beats a coincident timeout; the MDU result advances to M.
          state_d = ST_RUN;
        end else if (tmo_q == TMO_LAST) begin
          m_abort = 1'b1;
          err_d   = 1'b1;
          state_d = ST_RUN;
        end else begin
          s_f   = 1'b1;
          s_d   = 1'b1;
          s_e   = 1'b1;
          f_m   = 1'b1;
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign stall_F   = s_f     & ~reset;
  assign stall_D   = s_d     & ~reset;
  assign stall_E   = s_e     & ~reset;
  assign flush_D   = f_d     & ~reset;
  assign flush_E   = f_e     & ~reset;
  assign flush_M   = f_m     & ~reset;
  assign mdu_start = m_start & ~reset;
  assign mdu_abort = m_abort & ~reset;
  assign mdu_error    = err_q;
  assign stall_cycles = cyc_q;
  assign dbg_state    = state_q;

  // Stall-cycle counter: count each cycle where fetch is held, and stick at all-ones.
  always_comb begin
    cyc_d = cyc_q;
    if (stall_F && (cyc_q != {CNT_W{1'b1}})) cyc_d = cyc_q + 1'b1;
  end

  // State, timeout counter, error flag and stall counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
    end
  end

endmodule
